// File: rtl/psum_tile_scheduler.sv
// Layer-level sequencer for the partial-sum block: walks every output tile and,
// inside it, every input-channel pass, then raises a level interrupt.
module psum_tile_scheduler #(
    parameter int ADDR_W  = 11,
    parameter int BATCH_W = 6,
    parameter int COL_W   = 5,
    parameter int TILE_W  = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [TILE_W-1:0]  cfg_num_in,
    input  logic [TILE_W-1:0]  cfg_num_out,
    input  logic [ADDR_W-1:0]  cfg_base_addr,
    input  logic [ADDR_W-1:0]  cfg_stride,
    input  logic [BATCH_W-1:0] cfg_batch,
    input  logic [COL_W-1:0]   cfg_last_col,
    input  logic               abort,
    input  logic               irq_clr,
    output logic               ps_start,
    output logic               ps_accumulate,
    output logic [ADDR_W-1:0]  ps_address_start,
    output logic [BATCH_W-1:0] ps_batch,
    output logic [COL_W-1:0]   ps_last_col,
    input  logic               ps_done,
    output logic               busy,
    output logic               irq,
    output logic [TILE_W-1:0]  cur_out_tile,
    output logic [TILE_W-1:0]  cur_in_tile
);

    typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_DONE} state_t;

    state_t             state, state_nxt;
    logic [TILE_W-1:0]  num_in, num_out, o_cnt, i_cnt;
    logic [ADDR_W-1:0]  stride, addr;
    logic [BATCH_W-1:0] batch;
    logic [COL_W-1:0]   last_col;
    logic               done_q, done_rise;
    logic               accept, step_in, step_out, finish;

    // Only a fresh low-to-high transition of ps_done completes a pass.
    assign done_rise = ps_done & ~done_q;

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        step_in   = 1'b0;
        step_out  = 1'b0;
        finish    = 1'b0;
        case (state)
            S_IDLE, S_DONE: begin
                if (cfg_valid) begin
                    accept    = 1'b1;
                    state_nxt = S_LAUNCH;
                end
            end
            S_LAUNCH: state_nxt = abort ? S_IDLE : S_WAIT;
            S_WAIT: begin
                if (abort) begin
                    state_nxt = S_IDLE;
                end else if (done_rise) begin
                    if (i_cnt != num_in) begin
                        step_in   = 1'b1;
                        state_nxt = S_LAUNCH;
                    end else if (o_cnt != num_out) begin
                        step_out  = 1'b1;
                        state_nxt = S_LAUNCH;
                    end else begin
                        finish    = 1'b1;
                        state_nxt = S_DONE;
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        cfg_ready     = (state == S_IDLE) || (state == S_DONE);
        busy          = (state == S_LAUNCH) || (state == S_WAIT);
        ps_start      = (state == S_LAUNCH) && !abort;
        ps_accumulate = busy && (i_cnt != '0);
    end

    // Address accumulates stride per output tile instead of multiplying o*stride.
    always_ff @(posedge clk) begin
        if (rst) begin
            done_q   <= 1'b0;
            num_in   <= '0;
            num_out  <= '0;
            stride   <= '0;
            addr     <= '0;
            batch    <= '0;
            last_col <= '0;
            o_cnt    <= '0;
            i_cnt    <= '0;
            irq      <= 1'b0;
        end else begin
            done_q <= ps_done;
            if (accept) begin
                num_in   <= cfg_num_in;
                num_out  <= cfg_num_out;
                stride   <= cfg_stride;
                addr     <= cfg_base_addr;
                batch    <= cfg_batch;
                last_col <= cfg_last_col;
                o_cnt    <= '0;
                i_cnt    <= '0;
                irq      <= 1'b0;
            end else begin
                if (step_in) i_cnt <= i_cnt + 1'b1;
                if (step_out) begin
                    i_cnt <= '0;
                    o_cnt <= o_cnt + 1'b1;
                    addr  <= addr + stride;
                end
                if (finish)       irq <= 1'b1;
                else if (irq_clr) irq <= 1'b0;
            end
        end
    end

    assign ps_address_start = addr;
    assign ps_batch         = batch;
    assign ps_last_col      = last_col;
    assign cur_out_tile     = o_cnt;
    assign cur_in_tile      = i_cnt;

endmodule

// File: tb/tb_psum_tile_scheduler.sv
// Directed bench for psum_tile_scheduler with a counting ps_done responder.
module tb_psum_tile_scheduler;

    localparam int ADDR_W = 11, BATCH_W = 6, COL_W = 5, TILE_W = 8;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               cfg_valid = 1'b0;
    logic               cfg_ready;
    logic [TILE_W-1:0]  cfg_num_in = '0, cfg_num_out = '0;
    logic [ADDR_W-1:0]  cfg_base_addr = '0, cfg_stride = '0;
    logic [BATCH_W-1:0] cfg_batch = '0;
    logic [COL_W-1:0]   cfg_last_col = '0;
    logic               abort = 1'b0, irq_clr = 1'b0;
    logic               ps_start, ps_accumulate;
    logic [ADDR_W-1:0]  ps_address_start;
    logic [BATCH_W-1:0] ps_batch;
    logic [COL_W-1:0]   ps_last_col;
    logic               ps_done;
    logic               busy, irq;
    logic [TILE_W-1:0]  cur_out_tile, cur_in_tile;

    logic auto_done = 1'b1, model_done = 1'b0, man_done = 1'b0;
    assign ps_done = auto_done ? model_done : man_done;

    psum_tile_scheduler #(.ADDR_W(ADDR_W), .BATCH_W(BATCH_W), .COL_W(COL_W), .TILE_W(TILE_W)) dut (
        .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_num_in(cfg_num_in), .cfg_num_out(cfg_num_out), .cfg_base_addr(cfg_base_addr),
        .cfg_stride(cfg_stride), .cfg_batch(cfg_batch), .cfg_last_col(cfg_last_col),
        .abort(abort), .irq_clr(irq_clr), .ps_start(ps_start), .ps_accumulate(ps_accumulate),
        .ps_address_start(ps_address_start), .ps_batch(ps_batch), .ps_last_col(ps_last_col),
        .ps_done(ps_done), .busy(busy), .irq(irq),
        .cur_out_tile(cur_out_tile), .cur_in_tile(cur_in_tile)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Start logger plus responder: ps_done rises 5 cycles after each start, for one cycle.
    int          n_start = 0;
    int          rise_cyc = 0;
    int          cnt = 0;
    logic [10:0] log_addr [64];
    logic        log_acc  [64];
    logic [5:0]  log_batch[64];
    logic [4:0]  log_col  [64];
    always @(negedge clk) begin
        if (ps_start) begin
            if (n_start < 64) begin
                log_addr[n_start]  = ps_address_start;
                log_acc[n_start]   = ps_accumulate;
                log_batch[n_start] = ps_batch;
                log_col[n_start]   = ps_last_col;
            end
            n_start++;
            cnt = 6;
            model_done = 1'b0;
        end else if (cnt > 0) begin
            cnt--;
            model_done = (cnt == 1);
            if (cnt == 1) rise_cyc = cyc;
        end else begin
            model_done = 1'b0;
        end
    end

    int checks = 0, errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic start_job(input int ni, input int no, input int base, input int strd,
                             input int bt, input int lc, input logic clr);
        @(posedge clk); #1;
        cfg_num_in    = TILE_W'(ni);
        cfg_num_out   = TILE_W'(no);
        cfg_base_addr = ADDR_W'(base);
        cfg_stride    = ADDR_W'(strd);
        cfg_batch     = BATCH_W'(bt);
        cfg_last_col  = COL_W'(lc);
        cfg_valid     = 1'b1;
        irq_clr       = clr;
        @(negedge clk);
        chk("cfg_ready_at_start", cfg_ready, 1);
        @(posedge clk); #1;
        cfg_valid = 1'b0;
        irq_clr   = 1'b0;
    endtask

    task automatic wait_irq(input string tag);
        int n;
        n = 0;
        while (!irq && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk(tag, irq, 1);
    endtask

    logic [10:0] exp_addr[6];
    logic        exp_acc[6];
    int          b;

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_cfg_ready", cfg_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_irq", irq, 0);
        chk("rst_ps_start", ps_start, 0);
        chk("rst_addr", ps_address_start, 0);
        chk("rst_tiles", {cur_out_tile, cur_in_tile}, 0);

        // Single pass
        b = n_start;
        start_job(0, 0, 'h010, 0, 8, 31, 1'b0);
        wait_irq("single_irq");
        chk("single_irq_latency", cyc - rise_cyc, 1);
        chk("single_count", n_start - b, 1);
        chk("single_addr", log_addr[b], 'h010);
        chk("single_acc", log_acc[b], 0);
        chk("single_batch", log_batch[b], 8);
        chk("single_col", log_col[b], 31);
        chk("single_busy", busy, 0);

        // Accumulate ordering across two output tiles
        exp_addr = '{11'h100, 11'h100, 11'h100, 11'h140, 11'h140, 11'h140};
        exp_acc  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        b = n_start;
        start_job(2, 1, 'h100, 'h040, 4, 15, 1'b0);
        @(negedge clk);
        chk("acc_busy", busy, 1);
        wait_irq("acc_irq");
        chk("acc_count", n_start - b, 6);
        for (int k = 0; k < 6; k++) begin
            chk($sformatf("acc_addr%0d", k), log_addr[b+k], exp_addr[k]);
            chk($sformatf("acc_flag%0d", k), log_acc[b+k], exp_acc[k]);
        end
        chk("acc_final_tiles", {cur_out_tile, cur_in_tile}, {8'd1, 8'd2});

        // Address wrap
        b = n_start;
        start_job(0, 1, 'h7F0, 'h020, 1, 1, 1'b0);
        wait_irq("wrap_irq");
        chk("wrap_count", n_start - b, 2);
        chk("wrap_addr0", log_addr[b], 'h7F0);
        chk("wrap_addr1", log_addr[b+1], 'h010);

        // Stale done held high across LAUNCH
        auto_done = 1'b0;
        man_done  = 1'b1;
        b = n_start;
        start_job(1, 0, 'h020, 0, 2, 3, 1'b0);
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("stale_no_early", n_start - b, 1);
        @(posedge clk); #1 man_done = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("stale_low_gap", n_start - b, 1);
        @(posedge clk); #1 man_done = 1'b1;
        repeat (3) @(negedge clk);
        chk("stale_second", n_start - b, 2);
        chk("stale_second_acc", log_acc[b+1], 1);
        repeat (3) @(posedge clk);
        #1 man_done = 1'b0;
        repeat (2) @(posedge clk);
        #1 man_done = 1'b1;
        wait_irq("stale_irq");
        chk("stale_count", n_start - b, 2);
        man_done  = 1'b0;
        auto_done = 1'b1;

        // Abort on the second LAUNCH
        b = n_start;
        start_job(1, 0, 'h030, 0, 2, 3, 1'b0);
        repeat (6) @(posedge clk);
        #1 abort = 1'b1;
        @(negedge clk);
        chk("abort_no_start", ps_start, 0);
        @(posedge clk); #1 abort = 1'b0;
        @(negedge clk);
        chk("abort_count", n_start - b, 1);
        chk("abort_busy", busy, 0);
        chk("abort_irq", irq, 0);
        chk("abort_ready", cfg_ready, 1);

        // Reset in the middle of WAIT
        b = n_start;
        start_job(0, 0, 'h055, 0, 3, 7, 1'b0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("mrst_ready", cfg_ready, 1);
        chk("mrst_busy", busy, 0);
        chk("mrst_irq", irq, 0);
        chk("mrst_addr", ps_address_start, 0);
        chk("mrst_batch_col", {ps_batch, ps_last_col}, 0);
        chk("mrst_acc_tiles", {ps_accumulate, cur_out_tile, cur_in_tile}, 0);
        repeat (10) @(negedge clk);
        chk("mrst_count", n_start - b, 1);
        chk("mrst_irq_late", irq, 0);

        // irq_clr, then config acceptance coinciding with irq_clr
        start_job(0, 0, 'h000, 0, 1, 1, 1'b0);
        wait_irq("clr_irq_up");
        @(posedge clk); #1 irq_clr = 1'b1;
        @(posedge clk); #1 irq_clr = 1'b0;
        @(negedge clk);
        chk("clr_irq", irq, 0);
        chk("clr_ready", cfg_ready, 1);
        start_job(0, 0, 'h000, 0, 1, 1, 1'b0);
        wait_irq("clr2_irq_up");
        start_job(0, 0, 'h008, 0, 1, 1, 1'b1);
        @(negedge clk);
        chk("coinc_irq", irq, 0);
        chk("coinc_busy", busy, 1);
        wait_irq("coinc_done");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/psum_tile_scheduler.md
Name: psum_tile_scheduler

Overview:
- Sequences the partial-sum accumulation block across one layer's tiles.
- A host-side config handshake supplies the tile counts and BRAM layout.
- For every output tile, the scheduler runs all input-channel passes: the first pass overwrites, later passes accumulate.
- Each pass issues one start pulse to the partial-sum block and waits for its done. After the last pass of the last output tile, the scheduler raises a level interrupt.

Parameters:
- ADDR_W, 11, width of the partial-sum BRAM row address (address_start).
- BATCH_W, 6, width of the batch field.
- COL_W, 5, width of the last_col field.
- TILE_W, 8, width of the tile-count fields.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- cfg_valid  in  1  config request.
- cfg_ready  out  1  scheduler can accept config.
- cfg_num_in  in  TILE_W  input-channel passes minus 1.
- cfg_num_out  in  TILE_W  output tiles minus 1.
- cfg_base_addr  in  ADDR_W  BRAM row address of output tile 0.
- cfg_stride  in  ADDR_W  BRAM rows between consecutive output tiles.
- cfg_batch  in  BATCH_W  batch size forwarded to the partial-sum block.
- cfg_last_col  in  COL_W  last valid array column, forwarded.
- abort  in  1  cancel the running job.
- irq_clr  in  1  clear irq.
- ps_start  out  1  one-cycle start pulse to the partial-sum block.
- ps_accumulate  out  1  0 = overwrite, 1 = accumulate.
- ps_address_start  out  ADDR_W  row address for the current pass.
- ps_batch  out  BATCH_W  batch for the current pass.
- ps_last_col  out  COL_W  last column for the current pass.
- ps_done  in  1  done from the partial-sum block (level).
- busy  out  1  job in progress.
- irq  out  1  job-complete interrupt, level-high.
- cur_out_tile  out  TILE_W  output tile index in progress.
- cur_in_tile  out  TILE_W  input pass index in progress.

Behaviour:
- Reset values (rst sampled high at a clk edge): all outputs 0 except cfg_ready = 1; state = IDLE; edge-detect register cleared. Reset in any state aborts silently: no ps_start, no irq.
- States: IDLE, LAUNCH, WAIT, DONE.
- IDLE/DONE → LAUNCH:
  - cfg_ready = 1 only in IDLE and DONE.
  - On cfg_valid & cfg_ready, latch all cfg fields, set counters o = 0 and i = 0, clear irq, set busy = 1, go to LAUNCH.
- LAUNCH (exactly 1 cycle):
  - Drive ps_start = 1, ps_accumulate = (i != 0), ps_address_start = (base + o*stride) mod 2^ADDR_W.
  - Go to WAIT.
  - The address is held in an accumulator register: reset to base at job start, add stride on output-tile advance. No multiplier.
- WAIT:
  - ps_address_start, ps_accumulate, ps_batch and ps_last_col hold stable from LAUNCH until WAIT exits.
  - Pass completion = rising edge of ps_done (high now, low the previous cycle). A ps_done already high on WAIT entry does not count until it drops and rises.
  - On completion:
    - If i < num_in: i++, go to LAUNCH.
    - Else if o < num_out: i = 0, o++, address += stride, go to LAUNCH.
    - Else: go to DONE.
  - Minimum gap between consecutive ps_start pulses is 2 cycles.
- DONE (entry): busy = 0, irq = 1. irq stays high until irq_clr or new config acceptance. On the cycle where irq_clr and cfg acceptance coincide, the new job starts and irq = 0.
- abort: in LAUNCH or WAIT, return to IDLE next cycle, busy = 0, irq stays 0, and no ps_start is issued on that cycle (abort has priority over LAUNCH). abort in IDLE/DONE is ignored.
- ps_done edges outside WAIT are ignored. cfg_valid while busy is not accepted (cfg_ready = 0).
- Total ps_start pulses per job = (num_in+1)*(num_out+1).
- Address arithmetic wraps modulo 2^ADDR_W with no error flag.
- cur_out_tile and cur_in_tile reflect o and i; they are frozen at their final values in DONE.

Test Plan:
- Single pass: num_in = 0, num_out = 0, base = 0x010, batch = 8, last_col = 31, ps_done model returns 5 cycles after start → exactly one ps_start with accumulate = 0, addr = 0x010, batch = 8, last_col = 31; irq high 1 cycle after the ps_done rise; busy low.
- Accumulate ordering: num_in = 2, num_out = 1, base = 0x100, stride = 0x040 → 6 pulses with (addr, acc) = (100,0), (100,1), (100,1), (140,0), (140,1), (140,1); then irq.
- Wrap: base = 0x7F0, stride = 0x020, num_out = 1, num_in = 0 → addresses 0x7F0, then 0x010.
- Stale done: ps_done held high through LAUNCH, low 3 cycles, then high → only the later rise advances the pass; no early second ps_start.
- Abort/reset: assert abort the same cycle as the second LAUNCH → no second ps_start, busy = 0, irq = 0, cfg_ready = 1. Repeat the run with rst mid-WAIT → all outputs return to reset values.
- IRQ handling: in DONE, assert irq_clr → irq = 0. Then issue cfg_valid with irq_clr in the same cycle from DONE with irq high → new job accepted, irq = 0, busy = 1.
